fifo_word_serializer: RTL and testbench
=======================================

Name: fifo_word_serializer

Overview:
- Downstream consumer of the synchronous FIFO: pops one word at a time through the FIFO read port and shifts it out MSB-first on a bit-serial valid/ready link.
- Sits between the FIFO's read side (read_enable/data_out/empty/underflow) and a serial sink; provides frame markers, a word counter and a sticky error flag.
- Never issues a read while the FIFO reports empty.

Parameters:
- DATA_WIDTH, 8, FIFO word width / bits per serial frame (≥2).
- CNT_WIDTH, 16, width of the words_sent counter.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  permits starting a new word; an in-flight frame always completes
- fifo_data_out  in  DATA_WIDTH  FIFO read data, valid the cycle after a read_enable with empty=0
- fifo_empty  in  1  FIFO empty flag
- fifo_underflow  in  1  FIFO underflow pulse
- fifo_read_enable  out  1  single-cycle pop request to FIFO
- ser_data  out  1  serial bit
- ser_valid  out  1  ser_data valid
- ser_ready  in  1  sink accepts bit when ser_valid&&ser_ready
- ser_first  out  1  high with first bit (MSB) of a frame
- ser_last  out  1  high with final bit of a frame
- busy  out  1  high in any state other than IDLE
- words_sent  out  CNT_WIDTH  count of completed frames, wraps
- err_underflow  out  1  sticky: FIFO underflow observed

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; fifo_read_enable=0, ser_valid=0, ser_data=0, ser_first=0, ser_last=0, busy=0, words_sent=0, err_underflow=0, shift reg and bit index =0. Reset mid-frame abandons the frame; popped word is lost; no partial count.
- FSM states: IDLE, REQ, CAPTURE, SHIFT (+PARITY when macro on).
- IDLE: if enable && !fifo_empty -> REQ. Else stay.
- REQ: fifo_read_enable=1 for exactly this cycle -> CAPTURE.
- CAPTURE: load shift reg from fifo_data_out, bit index=0 -> SHIFT.
- SHIFT: ser_valid=1, ser_data=shift reg MSB, ser_first=(index==0), ser_last=(index==DATA_WIDTH-1, no parity). On handshake: shift left, index++. On handshake of last data bit: -> PARITY (macro on) or frame done.
- Frame done: words_sent += 1 (modulo 2^CNT_WIDTH); next state REQ if enable && !fifo_empty, else IDLE (back-to-back frames: 2-cycle gap, no ser_valid in REQ/CAPTURE).
- Backpressure: while ser_valid && !ser_ready, ser_data/ser_first/ser_last held stable; no state change.
- ser_valid never deasserts before handshake; enable low mid-frame has no effect until frame done.
- fifo_read_enable asserted only in REQ, which is entered only when fifo_empty=0 was sampled; never asserted two consecutive cycles.
- err_underflow set on any cycle fifo_underflow=1; cleared only by reset.
- Latency: enable && !empty in IDLE at cycle N -> read_enable at N+1 -> first ser_valid at N+3.

Optional Feature:
- Macro SERIAL_PARITY_EN.
- Defined: after last data bit, PARITY state drives ser_data = even parity (XOR of all DATA_WIDTH bits), ser_valid=1, ser_last=1; data-bit ser_last stays 0; frame = DATA_WIDTH+1 bits; count on parity handshake. Parity captured in CAPTURE.
- Undefined: no PARITY state, frame = DATA_WIDTH bits, ser_last on final data bit.

Decomposition:
- Shared package fifo_pkg: DATA_WIDTH default constant, ser_state_t enum (IDLE, REQ, CAPTURE, SHIFT, PARITY).
- Single module; no sub-module (bit counter and shift reg are small, inline).

Test Plan:
- FIFO holds 0xA5, enable=1, ser_ready=1 -> one read_enable pulse; bits 1,0,1,0,0,1,0,1 on consecutive cycles; ser_first on bit0, ser_last on bit7; words_sent=1; return IDLE.
- FIFO holds 0x3C,0xFF; ser_ready toggles 1/0 each cycle -> bits held while ready=0; both frames correct; exactly 2 read_enable pulses, 2-cycle gap; words_sent=2.
- FIFO empty, enable=1 for 50 cycles -> fifo_read_enable never asserted, ser_valid=0, busy=0.
- rst_n=0 at bit3 of 0x81 -> next cycle all outputs at reset values, words_sent=0; next word after reset serialized from MSB with ser_first.
- fifo_underflow pulsed one cycle -> err_underflow=1 and stays 1 until rst_n=0.
- SERIAL_PARITY_EN: 0xA5 -> 9th bit 0 with ser_last; 0x07 -> 9th bit 1; words_sent increments only after parity handshake.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and serializer state encoding for the FIFO read-side blocks
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    CAPTURE,
    SHIFT,
    PARITY
  } ser_state_t;

endpackage

// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - pops FIFO words and shifts them out MSB-first on a bit-serial link
// Optional even-parity trailer bit enabled by SERIAL_PARITY_EN.
module fifo_word_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_read_enable,
  output logic                  ser_data,
  output logic                  ser_valid,
  input  logic                  ser_ready,
  output logic                  ser_first,
  output logic                  ser_last,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  words_sent,
  output logic                  err_underflow
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  ser_state_t            state, state_next;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IDX_W-1:0]      idx;
  logic                  last_bit;
  logic                  frame_done;
`ifdef SERIAL_PARITY_EN
  logic                  parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      shreg         <= '0;
      idx           <= '0;
      words_sent    <= '0;
      err_underflow <= 1'b0;
`ifdef SERIAL_PARITY_EN
      parity_q      <= 1'b0;
`endif
    end else begin
      state <= state_next;
      if (fifo_underflow) err_underflow <= 1'b1;
      if (state == CAPTURE) begin
        shreg <= fifo_data_out;
        idx   <= '0;
`ifdef SERIAL_PARITY_EN
        parity_q <= ^fifo_data_out;
`endif
      end else if (state == SHIFT && ser_ready) begin
        shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
        idx   <= idx + 1'b1;
      end
      if (frame_done) words_sent <= words_sent + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next       = state;
    fifo_read_enable = 1'b0;
    ser_valid        = 1'b0;
    ser_data         = 1'b0;
    ser_first        = 1'b0;
    ser_last         = 1'b0;
    last_bit         = 1'b0;
    frame_done       = 1'b0;
    case (state)
      IDLE:    if (enable && !fifo_empty) state_next = REQ;
      REQ: begin
        fifo_read_enable = 1'b1;
        state_next       = CAPTURE;
      end
      CAPTURE: state_next = SHIFT;
      SHIFT: begin
        ser_valid = 1'b1;
        ser_data  = shreg[DATA_WIDTH-1];
        ser_first = (idx == '0);
        last_bit  = (idx == LAST_IDX);
`ifdef SERIAL_PARITY_EN
        if (ser_ready && last_bit) state_next = PARITY;
`else
        ser_last = last_bit;
        if (ser_ready && last_bit) frame_done = 1'b1;
`endif
      end
`ifdef SERIAL_PARITY_EN
      PARITY: begin
        ser_valid = 1'b1;
        ser_data  = parity_q;
        ser_last  = 1'b1;
        if (ser_ready) frame_done = 1'b1;
      end
`endif
      default: state_next = IDLE;
    endcase
    // A finished frame may chain straight into the next pop without visiting IDLE.
    if (frame_done) state_next = (enable && !fifo_empty) ? REQ : IDLE;
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb/tb_fifo_word_serializer.sv - randomized scoreboard bench for fifo_word_serializer
module tb_fifo_word_serializer;

  localparam int DW = 8;
  localparam int CW = 16;
`ifdef SERIAL_PARITY_EN
  localparam int FB = DW + 1;
`else
  localparam int FB = DW;
`endif

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          fifo_underflow;
  logic          fifo_read_enable;
  logic          ser_data;
  logic          ser_valid;
  logic          ser_ready;
  logic          ser_first;
  logic          ser_last;
  logic          busy;
  logic [CW-1:0] words_sent;
  logic          err_underflow;

  fifo_word_serializer #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .fifo_read_enable(fifo_read_enable),
    .ser_data(ser_data), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .ser_first(ser_first), .ser_last(ser_last),
    .busy(busy), .words_sent(words_sent), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic d;
    logic f;
    logic l;
  } bit_t;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];
  bit_t          exp_q[$];
  logic [CW-1:0] wcount = '0;
  bit            rd_seen = 0;
  int            rd_count = 0;
  int            n_pushed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected serial frame for a word: MSB first, optional even-parity trailer.
  function automatic void expand(input logic [DW-1:0] w);
    bit_t b;
    logic p;
    p = 1'b0;
    for (int i = 0; i < DW; i++) begin
      b.d = (w >> (DW - 1 - i)) & 1'b1;
      b.f = (i == 0);
      b.l = (FB == DW) && (i == DW - 1);
      p   = p ^ b.d;
      exp_q.push_back(b);
    end
`ifdef SERIAL_PARITY_EN
    b.d = p;
    b.f = 1'b0;
    b.l = 1'b1;
    exp_q.push_back(b);
`endif
  endfunction

  task automatic tick();
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    if (rd_seen) begin
      rd_seen = 0;
      if (fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        fifo_data_out = w;
        expand(w);
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    n_pushed++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    exp_q.delete();
    wcount   = '0;
    rd_seen  = 0;
    n_pushed = fifo_q.size();
    check("rst_valid", ser_valid, 0);
    check("rst_data", ser_data, 0);
    check("rst_first", ser_first, 0);
    check("rst_last", ser_last, 0);
    check("rst_rd", fifo_read_enable, 0);
    check("rst_busy", busy, 0);
    check("rst_words", words_sent, 0);
    check("rst_err", err_underflow, 0);
    rst_n = 1'b1;
  endtask

  // Scoreboard / protocol monitor, sampling on the falling edge.
  initial begin
    bit   prev_stall;
    bit   prev_rd;
    bit   prev_done_req;
    logic [2:0] prev_bits;
    bit_t e;
    prev_stall = 0;
    prev_rd = 0;
    prev_done_req = 0;
    prev_bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 0;
        prev_rd = 0;
        prev_done_req = 0;
      end else begin
        check("words_sent", words_sent, wcount);
        if (fifo_read_enable) begin
          check("rd_nonempty", fifo_empty, 0);
          check("rd_twice", prev_rd, 0);
          rd_count++;
          rd_seen = 1;
        end
        if (prev_done_req) check("b2b_req", fifo_read_enable, 1);
        if (prev_stall) begin
          check("hold_valid", ser_valid, 1);
          check("hold_bits", {ser_data, ser_first, ser_last}, prev_bits);
        end
        prev_done_req = 0;
        if (ser_valid && ser_ready) begin
          check("stream_len", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("ser_data", ser_data, e.d);
            check("ser_first", ser_first, e.f);
            check("ser_last", ser_last, e.l);
            if (e.l) begin
              wcount = wcount + 1'b1;
              prev_done_req = enable && !fifo_empty;
            end
          end
        end
        prev_stall = ser_valid && !ser_ready;
        prev_bits  = {ser_data, ser_first, ser_last};
        prev_rd    = fifo_read_enable;
      end
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    enable = 1'b0;
    ser_ready = 1'b0;
    fifo_data_out = '0;
    fifo_empty = 1'b1;
    fifo_underflow = 1'b0;
    do_reset();

    rd_count = 0;
    push(8'hA5);
    enable = 1'b1;
    ser_ready = 1'b1;
    repeat (16) tick();
    check("t1_rd_pulses", rd_count, 1);
    check("t1_words", words_sent, 1);
    check("t1_idle", busy, 0);
    check("t1_drained", exp_q.size(), 0);

    rd_count = 0;
    push(8'h3C);
    push(8'hFF);
    repeat (60) begin
      ser_ready = ~ser_ready;
      tick();
    end
    ser_ready = 1'b1;
    check("t2_rd_pulses", rd_count, 2);
    check("t2_words", words_sent, 3);
    check("t2_idle", busy, 0);

    repeat (50) begin
      tick();
      check("t3_rd", fifo_read_enable, 0);
      check("t3_valid", ser_valid, 0);
      check("t3_busy", busy, 0);
    end

    push(8'h81);
    n = 0;
    while (!(ser_valid && ser_first) && n < 20) begin
      tick();
      n++;
    end
    check("t4_start", ser_valid && ser_first, 1);
    repeat (3) tick();
    do_reset();
    push(8'hC3);
    n = 0;
    while (!ser_valid && n < 20) begin
      tick();
      n++;
    end
    check("t4_restart_valid", ser_valid, 1);
    check("t4_restart_first", ser_first, 1);
    check("t4_restart_msb", ser_data, 1);
    repeat (20) tick();
    check("t4_words", words_sent, 1);

    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    tick();
    check("t5_err_set", err_underflow, 1);
    repeat (5) tick();
    check("t5_err_sticky", err_underflow, 1);
    do_reset();

    push(8'hA5);
    push(8'h07);
    for (int c = 0; c < 3000; c++) begin
      enable    = ($urandom_range(0, 7) != 0);
      ser_ready = ($urandom_range(0, 2) != 0);
      if (fifo_q.size() < 6 && ($urandom_range(0, 3) == 0)) push(DW'($urandom));
      tick();
    end
    enable = 1'b1;
    ser_ready = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    check("t6_drained", busy || exp_q.size() != 0 || fifo_q.size() != 0, 0);
    check("t6_words", words_sent, CW'(n_pushed));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
